// File: rtl/alu_tx_pkg.sv
// alu_tx_pkg: shared definitions for the ALU result sender.
//   tx_state_e : sender FSM states (idle, sending a frame)
//   ByteW      : width of one serialized byte on the TX stream
package alu_tx_pkg;

  localparam int unsigned ByteW = 8;

  typedef enum logic {
    StIdle,
    StSend
  } tx_state_e;

endpackage

// File: rtl/result_fifo.sv
// result_fifo: synchronous FIFO holding ALU results awaiting serialization.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   wr_en, wr_data   : push a word (caller guarantees space, or a same-cycle pop)
//   rd_en, rd_data   : pop the head; rd_data shows the head combinationally
//   full, empty      : occupancy flags
//   count            : number of stored entries, 0..DEPTH
module result_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = PtrW + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q;

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (wr_en && !rd_en) begin
        count_q <= count_q + CountW'(1);
      end else if (!wr_en && rd_en) begin
        count_q <= count_q - CountW'(1);
      end
    end
  end

  // Head is read before a same-cycle write lands, so write+read when full is safe.
  assign rd_data = mem[rd_ptr_q];
  assign full    = (count_q == CountW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/alu_result_sender.sv
// alu_result_sender: buffers ALU result strobes and serializes each result
// LSB-byte-first onto a byte-wide valid/ready stream toward the UART TX path.
// Ports:
//   CLK, RST           : clock, synchronous active-high reset
//   ALU_OUT, OUT_VALID : result word and its single-cycle strobe
//   TX_DATA, TX_VALID  : byte stream toward the transmitter
//   TX_READY           : transmitter accepts the current byte
//   OVERFLOW           : sticky, a result was dropped for lack of space
//   BUSY               : results queued or a frame in progress
module alu_result_sender
  import alu_tx_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [OUT_WIDTH-1:0] ALU_OUT,
  input  logic                 OUT_VALID,
  output logic [ByteW-1:0]     TX_DATA,
  output logic                 TX_VALID,
  input  logic                 TX_READY,
  output logic                 OVERFLOW,
  output logic                 BUSY
);

  localparam int unsigned NBytes = OUT_WIDTH / ByteW;
  localparam int unsigned CntW   = (NBytes > 1) ? $clog2(NBytes) : 1;
  localparam int unsigned CountW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NBytes - 1);

  tx_state_e            state_q, state_d;
  logic [OUT_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]      byte_cnt_q, byte_cnt_d;
  logic                 overflow_q, overflow_d;
  logic                 busy_q, busy_d;

  logic                 push, pop;
  logic [OUT_WIDTH-1:0] fifo_head;
  logic                 fifo_full, fifo_empty;
  logic [CountW-1:0]    fifo_count, count_d;

  result_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (push),
    .wr_data (ALU_OUT),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // A full FIFO still accepts a strobe when the head leaves in the same cycle.
  assign push = OUT_VALID & (~fifo_full | pop);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    pop        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_head;
          byte_cnt_d = '0;
          state_d    = StSend;
        end
      end
      StSend: begin
        // TX_VALID is always high here, so TX_READY alone marks a handshake.
        if (TX_READY) begin
          if (byte_cnt_q != LastCnt) begin
            shift_d    = shift_q >> ByteW;
            byte_cnt_d = byte_cnt_q + CntW'(1);
          end else if (!fifo_empty) begin
            // Chain straight into the next frame without a bubble.
            pop        = 1'b1;
            shift_d    = fifo_head;
            byte_cnt_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q | (OUT_VALID & ~push);
    count_d    = fifo_count + CountW'(push) - CountW'(pop);
    // Computed from next-state values so the flop mirrors the current occupancy.
    busy_d     = (count_d != '0) | (state_d == StSend);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
    end
  end

  assign TX_DATA  = shift_q[ByteW-1:0];
  assign TX_VALID = (state_q == StSend);
  assign OVERFLOW = overflow_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_alu_result_sender.sv
// tb_alu_result_sender: self-checking bench for alu_result_sender.
// A queue-based reference model (pending words, bytes left in the current
// frame, sticky drop flag) is compared against the DUT on every negedge;
// directed scenarios add literal expectations, then randomized traffic runs.
module tb_alu_result_sender;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 4;
  localparam int unsigned NB = W / 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] ALU_OUT;
  logic         OUT_VALID;
  logic [7:0]   TX_DATA;
  logic         TX_VALID;
  logic         TX_READY;
  logic         OVERFLOW;
  logic         BUSY;

  int n_cmp = 0;
  int n_err = 0;

  alu_result_sender #(
    .OUT_WIDTH (W),
    .DEPTH     (D)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ALU_OUT   (ALU_OUT),
    .OUT_VALID (OUT_VALID),
    .TX_DATA   (TX_DATA),
    .TX_VALID  (TX_VALID),
    .TX_READY  (TX_READY),
    .OVERFLOW  (OVERFLOW),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_fifo[$];
  logic [7:0]   m_frame[$];
  bit           m_ovf;
  bit           m_ok = 1'b0;
  bit           m_rst_seen = 1'b0;
  bit           m_hs, m_pop, m_acc;
  logic [W-1:0] m_word;

  always @(posedge CLK) begin
    m_rst_seen = RST;
    if (RST) begin
      m_fifo.delete();
      m_frame.delete();
      m_ovf = 1'b0;
      m_ok  = 1'b1;
    end else if (m_ok) begin
      m_hs  = (m_frame.size() != 0) && TX_READY;
      m_pop = (m_fifo.size() != 0) &&
              ((m_frame.size() == 0) || (m_hs && m_frame.size() == 1));
      m_acc = OUT_VALID && ((m_fifo.size() < D) || m_pop);
      if (m_hs) void'(m_frame.pop_front());
      if (m_pop) begin
        m_word = m_fifo.pop_front();
        for (int b = 0; b < NB; b++) m_frame.push_back(m_word[8*b +: 8]);
      end
      if (m_acc) m_fifo.push_back(ALU_OUT);
      else if (OUT_VALID) m_ovf = 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (m_ok) begin
      chk("model_tx_valid", {15'b0, TX_VALID}, {15'b0, m_frame.size() != 0});
      chk("model_busy", {15'b0, BUSY},
          {15'b0, (m_fifo.size() != 0) || (m_frame.size() != 0)});
      chk("model_overflow", {15'b0, OVERFLOW}, {15'b0, m_ovf});
      if (m_frame.size() != 0) chk("model_tx_data", {8'b0, TX_DATA}, {8'b0, m_frame[0]});
      if (m_rst_seen) chk("model_reset_tx_data", {8'b0, TX_DATA}, 16'h0000);
    end
  end

  // ---------------- stimulus and literal checks ----------------
  function automatic logic [15:0] s5_word(input int k);
    logic [7:0] hi, lo;
    hi = 8'h10 + 8'(k);
    lo = 8'hA0 + 8'(k);
    return {hi, lo};
  endfunction

  logic [7:0]  exp_b[$];
  logic [15:0] tmp;

  initial begin
    RST = 1'b1; OUT_VALID = 1'b0; TX_READY = 1'b0; ALU_OUT = '0;
    repeat (3) tick();
    chk("reset_tx_valid", {15'b0, TX_VALID}, 16'h0);
    chk("reset_busy", {15'b0, BUSY}, 16'h0);
    chk("reset_overflow", {15'b0, OVERFLOW}, 16'h0);
    chk("reset_tx_data", {8'b0, TX_DATA}, 16'h0);
    RST = 1'b0;
    tick();

    // Single result
    TX_READY = 1'b1; ALU_OUT = 16'hA55A; OUT_VALID = 1'b1;
    tick();
    OUT_VALID = 1'b0;
    chk("s1_busy_n1", {15'b0, BUSY}, 16'h1);
    chk("s1_valid_n1", {15'b0, TX_VALID}, 16'h0);
    tick();
    chk("s1_valid_n2", {15'b0, TX_VALID}, 16'h1);
    chk("s1_byte0", {8'b0, TX_DATA}, 16'h005A);
    tick();
    chk("s1_byte1", {8'b0, TX_DATA}, 16'h00A5);
    tick();
    chk("s1_valid_n4", {15'b0, TX_VALID}, 16'h0);
    chk("s1_busy_n4", {15'b0, BUSY}, 16'h0);
    tick();

    // Backpressure
    TX_READY = 1'b0; ALU_OUT = 16'hA55A; OUT_VALID = 1'b1;
    tick();
    OUT_VALID = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("s2_hold_valid", {15'b0, TX_VALID}, 16'h1);
      chk("s2_hold_data", {8'b0, TX_DATA}, 16'h005A);
      tick();
    end
    TX_READY = 1'b1;
    chk("s2_byte0", {8'b0, TX_DATA}, 16'h005A);
    tick();
    chk("s2_byte1", {8'b0, TX_DATA}, 16'h00A5);
    tick();
    chk("s2_done", {15'b0, TX_VALID}, 16'h0);
    tick();

    // Back-to-back
    TX_READY = 1'b1; ALU_OUT = 16'h1234; OUT_VALID = 1'b1;
    tick();
    ALU_OUT = 16'hBEEF;
    tick();
    OUT_VALID = 1'b0;
    exp_b = '{8'h34, 8'h12, 8'hEF, 8'hBE};
    foreach (exp_b[i]) begin
      chk("s4_valid", {15'b0, TX_VALID}, 16'h1);
      chk("s4_byte", {8'b0, TX_DATA}, {8'b0, exp_b[i]});
      tick();
    end
    chk("s4_done", {15'b0, TX_VALID}, 16'h0);
    tick();

    // Full plus pop
    TX_READY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ALU_OUT = s5_word(k); OUT_VALID = 1'b1;
      tick();
    end
    OUT_VALID = 1'b0; TX_READY = 1'b1;
    tmp = s5_word(0);
    chk("s5_w0_lo", {8'b0, TX_DATA}, {8'b0, tmp[7:0]});
    tick();
    ALU_OUT = s5_word(5); OUT_VALID = 1'b1;
    chk("s5_w0_hi", {8'b0, TX_DATA}, {8'b0, tmp[15:8]});
    tick();
    OUT_VALID = 1'b0; TX_READY = 1'b0;
    chk("s5_no_overflow", {15'b0, OVERFLOW}, 16'h0);
    TX_READY = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tmp = s5_word(k);
      for (int b = 0; b < 2; b++) begin
        chk("s5_drain_valid", {15'b0, TX_VALID}, 16'h1);
        chk("s5_drain_byte", {8'b0, TX_DATA}, {8'b0, tmp[8*b +: 8]});
        tick();
      end
    end
    chk("s5_done", {15'b0, TX_VALID}, 16'h0);
    chk("s5_overflow_end", {15'b0, OVERFLOW}, 16'h0);
    tick();

    // Overflow
    TX_READY = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      ALU_OUT = 16'(k); OUT_VALID = 1'b1;
      tick();
    end
    OUT_VALID = 1'b0;
    chk("s3_overflow_set", {15'b0, OVERFLOW}, 16'h1);
    TX_READY = 1'b1;
    exp_b = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00};
    foreach (exp_b[i]) begin
      chk("s3_valid", {15'b0, TX_VALID}, 16'h1);
      chk("s3_byte", {8'b0, TX_DATA}, {8'b0, exp_b[i]});
      tick();
    end
    chk("s3_done", {15'b0, TX_VALID}, 16'h0);
    chk("s3_overflow_sticky", {15'b0, OVERFLOW}, 16'h1);
    tick();

    // Reset mid-frame (OVERFLOW still set from the previous scenario)
    TX_READY = 1'b1; ALU_OUT = 16'hA55A; OUT_VALID = 1'b1;
    tick();
    ALU_OUT = 16'h1111;
    tick();
    ALU_OUT = 16'h2222;
    chk("s6_byte0", {8'b0, TX_DATA}, 16'h005A);
    tick();
    OUT_VALID = 1'b0; RST = 1'b1;
    chk("s6_byte1_pending", {8'b0, TX_DATA}, 16'h00A5);
    tick();
    RST = 1'b0;
    chk("s6_valid", {15'b0, TX_VALID}, 16'h0);
    chk("s6_busy", {15'b0, BUSY}, 16'h0);
    chk("s6_overflow", {15'b0, OVERFLOW}, 16'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("s6_quiet", {15'b0, TX_VALID}, 16'h0);
    end

    // Randomized traffic, model-checked every cycle
    for (int seg = 0; seg < 4; seg++) begin
      for (int c = 0; c < 1000; c++) begin
        OUT_VALID = ($urandom_range(0, 9) < 4);
        ALU_OUT   = 16'($urandom);
        TX_READY  = ($urandom_range(0, 9) < (2 + 3 * seg));
        RST       = ($urandom_range(0, 499) == 0);
        tick();
      end
    end
    OUT_VALID = 1'b0; RST = 1'b0; TX_READY = 1'b1;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_sender.md
# alu_result_sender

Consumer for the ALU result interface. It accepts each `ALU_OUT`/`OUT_VALID` result pulse from the ALU units (compare, arithmetic, logic, shift) and buffers results in a small FIFO. Each result is serialized LSB-byte-first onto a byte-wide valid/ready stream that feeds the UART TX path. It sits between the ALU and the UART TX FIFO in the system controller's response path.

## Interface
Parameters:
- `OUT_WIDTH`, 16, ALU result width; must be a multiple of 8, minimum 8.
- `DEPTH`, 4, result FIFO depth in entries; power of two, minimum 2.

Ports:
- `CLK`  in  1  system clock; single clock domain.
- `RST`  in  1  reset, synchronous, active-high.
- `ALU_OUT`  in  OUT_WIDTH  result word; sampled only when `OUT_VALID`=1.
- `OUT_VALID`  in  1  single-cycle result strobe.
- `TX_DATA`  out  8  byte to transmitter.
- `TX_VALID`  out  1  `TX_DATA` is valid.
- `TX_READY`  in  1  transmitter accepts the byte this cycle.
- `OVERFLOW`  out  1  sticky; a result was dropped.
- `BUSY`  out  1  FIFO non-empty or frame in progress.

## Operation
- Constant NBYTES = OUT_WIDTH/8.
- **Capture:**
  - A result is written when `OUT_VALID`=1 and either count < DEPTH or a pop happens in the same cycle.
  - Otherwise the result is dropped and `OVERFLOW` is set.
  - `OVERFLOW` is cleared only by `RST`.
- **FSM states:** IDLE, SEND.
- **IDLE:**
  - If the FIFO is non-empty: pop the head into the shift register, set byte_cnt=0, set `TX_VALID`=1, go to SEND.
  - Otherwise stay in IDLE with `TX_VALID`=0.
- **SEND:**
  - `TX_DATA` is shift_reg[7:0].
  - Handshake = `TX_VALID` & `TX_READY`.
  - Handshake with byte_cnt < NBYTES-1: shift right by 8, byte_cnt+1.
  - Handshake with byte_cnt = NBYTES-1 and FIFO non-empty: pop the next word into the shift register, byte_cnt=0, stay in SEND with `TX_VALID`=1. There is no bubble between frames.
  - Handshake with byte_cnt = NBYTES-1 and FIFO empty: go to IDLE, `TX_VALID`=0.
  - No handshake: `TX_DATA`, `TX_VALID` and byte_cnt hold.
- **Handshake rule:** once `TX_VALID` is raised, it and `TX_DATA` stay stable until accepted. `TX_VALID` never depends combinationally on `TX_READY`.
- **Capacity:** DEPTH FIFO entries plus one word in the shift register.
- **Width rule:** byte_cnt is clog2(NBYTES) bits, 1 bit minimum. FIFO count is clog2(DEPTH)+1 bits, range 0..DEPTH. FIFO pointers wrap modulo DEPTH.
- **Reset values:** `TX_DATA`=0, `TX_VALID`=0, `OVERFLOW`=0, `BUSY`=0. FIFO empty, FSM in IDLE, byte_cnt=0.
- **Reset mid-frame:** the frame in progress and all queued results are discarded. No residual bytes are emitted.
- `BUSY` = (count ≠ 0) | (state = SEND), registered.

## Timing
- `OUT_VALID` in cycle n: the word is in the FIFO from n+1. From IDLE, the first byte has `TX_VALID`=1 in n+2.
- With `TX_READY` held at 1, one byte per cycle. A result takes NBYTES cycles, and back-to-back results stream continuously.
- `OVERFLOW` rises in the cycle after the dropped strobe.
- Write and pop may occur in the same cycle, including when the FIFO is full; count is then unchanged.
- `RST` takes effect at the next `CLK` edge; all outputs show reset values in the following cycle.

## Structure
- Package `alu_tx_pkg`: state encoding (IDLE, SEND) and the byte-width constant (8).
- NBYTES and the counter widths are derived locally from the parameters.
- Sub-module `result_fifo`:
  - synchronous FIFO parameterized by width and depth;
  - ports `wr_en`, `wr_data`, `rd_en`, `rd_data`, `full`, `empty`, `count`;
  - `rd_data` shows the head combinationally.
- Top level holds the FSM, shift register, byte counter and `OVERFLOW`/`BUSY` flags.

## Test plan
All scenarios use OUT_WIDTH=16 and DEPTH=4.
1. **Single result:** `ALU_OUT`=0xA55A with `OUT_VALID` in cycle n, `TX_READY`=1 → `TX_DATA`=0x5A in n+2, 0xA5 in n+3; `TX_VALID`=0 in n+4; `BUSY` falls after the last byte.
2. **Backpressure:** as scenario 1 with `TX_READY`=0 for cycles n+2..n+6 → `TX_DATA` holds 0x5A with `TX_VALID`=1. `TX_READY`=1 at n+7 → 0xA5 in n+8.
3. **Overflow:** `TX_READY`=0; strobes 0x0001..0x0006 in consecutive cycles → 0x0006 dropped, `OVERFLOW`=1. Then `TX_READY`=1 → bytes 01,00,02,00,03,00,04,00,05,00 with no gaps. `OVERFLOW` stays 1.
4. **Back-to-back:** 0x1234 and 0xBEEF in adjacent cycles, `TX_READY`=1 → 34,12,EF,BE on four consecutive cycles.
5. **Full plus pop:** with the FIFO full and the final byte of the current frame accepted in cycle m, `OUT_VALID` in m → the word is accepted and `OVERFLOW` stays 0.
6. **Reset mid-frame:** `RST` asserted after 0x5A is accepted, with two more words queued → `TX_VALID`=0, `BUSY`=0 and `OVERFLOW`=0 in the cycle after the reset edge. No further bytes are emitted.
